// File: rtl/seven_segment_reader.sv
// ============================================================================
// Module   : seven_segment_reader
// Purpose  : Captures a scanned, multiplexed 7-segment display bus. Each
//            {an_in, seg_in} dwell is qualified for stability, decoded back
//            to BCD and assembled into complete multi-digit frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_reader #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   an_in,
   output logic [4*NUM_DIGITS-1:0] value_out,
   output logic                    frame_valid,
   output logic                    frame_err,
   output logic                    seq_err
);

   localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [7:0]      C_CNT_FIRE = 8'(STABLE_CYCLES - 2);
   localparam logic [IDXW-1:0] C_IDX_ONE  = IDXW'(1);
   localparam logic [IDXW-1:0] C_IDX_LAST = IDXW'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {SYNC = 1'b0, COLLECT = 1'b1} state_t;

   state_t                  r_state, w_state_nxt;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [6:0]              r_seg;
   logic [7:0]              r_cnt;
   logic [IDXW-1:0]         r_exp, w_exp_nxt;
   logic                    r_acc, w_acc_nxt;
   logic [3:0]              r_slots [NUM_DIGITS];

   logic                    w_same, w_strobe, w_blank, w_onehot, w_illegal;
   logic [IDXW-1:0]         w_idx;
   logic [3:0]              w_nib;
   logic                    w_store, w_publish, w_seq;
   logic [4*NUM_DIGITS-1:0] w_frame;

   // Segment pattern (active-low, bit0=a) to {illegal, nibble}.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      case (seg)
         7'b1000000: decode = 5'h00;
         7'b1111001: decode = 5'h01;
         7'b0100100: decode = 5'h02;
         7'b0110000: decode = 5'h03;
         7'b0011001: decode = 5'h04;
         7'b0010010: decode = 5'h05;
         7'b0000010: decode = 5'h06;
         7'b1111000: decode = 5'h07;
         7'b0000000: decode = 5'h08;
         7'b0010000: decode = 5'h09;
         default:    decode = 5'h1F;
      endcase
   endfunction

   // Dwell qualification: strobe once on the STABLE_CYCLES-th identical edge.
   always_comb begin
      w_same   = ({an_in, seg_in} == {r_an, r_seg});
      w_strobe = w_same && (r_cnt == C_CNT_FIRE);
      w_blank  = &r_an;
      w_onehot = $onehot(~r_an);
      {w_illegal, w_nib} = decode(r_seg);
      w_idx = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (!r_an[k]) w_idx = IDXW'(k);
      end
   end

   // Sample register and saturating dwell counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an  <= '1;
         r_seg <= '1;
         r_cnt <= '0;
      end else begin
         r_an  <= an_in;
         r_seg <= seg_in;
         if (!w_same)             r_cnt <= '0;
         else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      end
   end

   // Frame-assembly next state: scan order tracking and publish decision.
   always_comb begin
      w_state_nxt = r_state;
      w_exp_nxt   = r_exp;
      w_acc_nxt   = r_acc;
      w_store     = 1'b0;
      w_publish   = 1'b0;
      w_seq       = 1'b0;
      if (w_strobe && !w_blank) begin
         if (!w_onehot) begin
            w_seq       = 1'b1;
            w_state_nxt = SYNC;
         end else if (r_state == SYNC) begin
            if (w_idx == '0) begin
               w_store     = 1'b1;
               w_acc_nxt   = w_illegal;
               w_exp_nxt   = C_IDX_ONE;
               w_state_nxt = COLLECT;
               if (NUM_DIGITS == 1) begin
                  w_publish   = 1'b1;
                  w_state_nxt = SYNC;
               end
            end
         end else begin
            if (w_idx == r_exp) begin
               w_store   = 1'b1;
               w_acc_nxt = r_acc | w_illegal;
               w_exp_nxt = r_exp + C_IDX_ONE;
               if (w_idx == C_IDX_LAST) begin
                  w_publish   = 1'b1;
                  w_state_nxt = SYNC;
               end
            end else if (w_idx == '0) begin
               // Scanner wrapped early: restart the frame quietly.
               w_store   = 1'b1;
               w_acc_nxt = w_illegal;
               w_exp_nxt = C_IDX_ONE;
            end else begin
               w_seq       = 1'b1;
               w_state_nxt = SYNC;
            end
         end
      end
   end

   // Candidate frame: stored slots with the digit being captured merged in.
   always_comb begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
         w_frame[4*k +: 4] = (w_store && (w_idx == IDXW'(k))) ? w_nib : r_slots[k];
      end
   end

   // State, slot storage and published outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= SYNC;
         r_exp       <= '0;
         r_acc       <= 1'b0;
         for (int k = 0; k < NUM_DIGITS; k++) r_slots[k] <= 4'h0;
         value_out   <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         seq_err     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_exp       <= w_exp_nxt;
         r_acc       <= w_acc_nxt;
         frame_valid <= w_publish;
         seq_err     <= w_seq;
         if (w_store) r_slots[w_idx] <= w_nib;
         if (w_publish) begin
            value_out <= w_frame;
            frame_err <= w_acc_nxt;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_reader.sv
// ============================================================================
// Module   : tb_seven_segment_reader
// Purpose  : Scoreboard bench for seven_segment_reader (4 digits, dwell 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segment_reader;

   localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                          P3 = 7'b0110000, P6 = 7'b0000010, P7 = 7'b1111000,
                          P8 = 7'b0000000, P9 = 7'b0010000, PX = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  seg_in = 7'h7F;
   logic [3:0]  an_in = 4'hF;
   logic [15:0] value_out;
   logic        frame_valid, frame_err, seq_err;

   typedef struct {
      bit          is_frame;
      logic [15:0] val;
      logic        err;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   seven_segment_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
      .value_out(value_out), .frame_valid(frame_valid),
      .frame_err(frame_err), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Hold one digit for n edges, followed by a 2-cycle blank gap.
   task automatic show(input int k, input logic [6:0] seg, input int n);
      @(negedge clk);
      an_in  = ~(4'b0001 << k);
      seg_in = seg;
      repeat (n - 1) @(negedge clk);
      @(negedge clk);
      an_in  = 4'hF;
      seg_in = PX;
      repeat (1) @(negedge clk);
   endtask

   task automatic scan(input logic [6:0] s0, s1, s2, s3);
      show(0, s0, 6); show(1, s1, 6); show(2, s2, 6); show(3, s3, 6);
   endtask

   task automatic push_frame(input logic [15:0] v, input logic e);
      ev_t ev;
      ev.is_frame = 1'b1; ev.val = v; ev.err = e;
      exp_q.push_back(ev);
   endtask

   task automatic push_seq();
      ev_t ev;
      ev.is_frame = 1'b0; ev.val = '0; ev.err = 1'b0;
      exp_q.push_back(ev);
   endtask

   // Monitor: every output event must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && (frame_valid || seq_err)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: frame_valid=%0b seq_err=%0b value=%h, none expected",
                     frame_valid, seq_err, value_out);
         end else begin
            ev_t ev;
            ev = exp_q.pop_front();
            check("event_is_frame", {31'b0, frame_valid}, {31'b0, ev.is_frame});
            check("event_is_seq",   {31'b0, seq_err},     {31'b0, !ev.is_frame});
            if (ev.is_frame) begin
               check("frame_value", {16'b0, value_out}, {16'b0, ev.val});
               check("frame_err",   {31'b0, frame_err}, {31'b0, ev.err});
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check("rst_value",  {16'b0, value_out},   32'h0);
      check("rst_valid",  {31'b0, frame_valid}, 32'h0);
      check("rst_ferr",   {31'b0, frame_err},   32'h0);
      check("rst_seqerr", {31'b0, seq_err},     32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Clean frame 3,2,1,0
      push_frame(16'h0123, 1'b0);
      scan(P3, P2, P1, P0);

      // Illegal pattern on digit 2, then a clean frame again
      push_frame(16'h0F23, 1'b1);
      scan(P3, P2, PX, P0);
      push_frame(16'h0123, 1'b0);
      scan(P3, P2, P1, P0);

      // Digit 1 too short: digit 2 arrives out of order
      push_seq();
      show(0, P3, 6); show(1, P2, 3); show(2, P1, 6); show(3, P0, 6);
      repeat (3) @(negedge clk);
      check("hold_value", {16'b0, value_out}, 32'h0123);
      check("hold_ferr",  {31'b0, frame_err}, 32'h0);

      // Two selects active at once while collecting
      push_seq();
      show(0, P3, 6);
      @(negedge clk); an_in = 4'b1100; seg_in = P8;
      repeat (6) @(negedge clk);
      an_in = 4'hF; seg_in = PX;
      repeat (2) @(negedge clk);
      push_frame(16'h0123, 1'b0);
      scan(P3, P2, P1, P0);

      // Early wrap to digit 0 restarts quietly; long dwell captures once
      push_frame(16'h6789, 1'b0);
      show(0, P9, 6); show(1, P8, 6); show(0, P9, 6);
      show(1, P8, 20); show(2, P7, 6); show(3, P6, 6);

      // Asynchronous reset in mid-frame
      show(0, P3, 6); show(1, P2, 6);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_value", {16'b0, value_out},   32'h0);
      check("mid_rst_ferr",  {31'b0, frame_err},   32'h0);
      check("mid_rst_valid", {31'b0, frame_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      show(2, P1, 6); show(3, P0, 6);
      check("post_rst_hold", {16'b0, value_out}, 32'h0);
      push_frame(16'h0123, 1'b0);
      scan(P3, P2, P1, P0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
Reverse direction of the segment decoder: observes a multiplexed, scanned 7-segment display bus (active-low segments plus active-low digit selects). It qualifies each dwell for stability, maps each segment pattern back to a BCD digit and assembles complete multi-digit frames. It is used as a display-capture and self-check monitor beside the multiplier's display path.

Parameters:
NUM_DIGITS, 4, number of scanned digits; digit 0 is the least-significant nibble; legal range 1..8
STABLE_CYCLES, 4, consecutive clock edges a {an_in, seg_in} pair must hold before capture; legal range 2..255

Ports:
clk  input  1  single clock; all logic rising-edge
rst_n  input  1  asynchronous, active-low reset
seg_in  input  7  active-low segments, bit0=a … bit6=g; synchronous to clk
an_in  input  NUM_DIGITS  active-low digit enables; one-hot-low selects a digit, all-ones means blank
value_out  output  4*NUM_DIGITS  last published frame; digit k is in bits [4k+3:4k]
frame_valid  output  1  one-cycle pulse when value_out updates
frame_err  output  1  updated with frame_valid; 1 = at least one digit in that frame had an illegal pattern
seq_err  output  1  one-cycle pulse on a scan-order or select violation

Behaviour:
- Reset (async, rst_n=0):
  - value_out=0, frame_valid=0, frame_err=0, seq_err=0.
  - Dwell counter=0, sample registers=all-ones, state=SYNC, expected index=0, error accumulator=0.
- Dwell qualification:
  - The block registers {an_in, seg_in} every edge.
  - The counter clears when the incoming pair differs from the registered pair, and increments (saturating) when equal.
  - One capture strobe fires on the edge where the pair has been identical for STABLE_CYCLES consecutive edges.
  - A dwell fires at most once, however long it is held. Changing the pair and then returning to it starts a new dwell.
- Select classification at the strobe:
  - All-ones: blank, ignored, no state change.
  - Exactly one zero at bit k: capture of digit k.
  - More than one zero: seq_err pulse, state goes to SYNC.
- Pattern map, seg_in→nibble:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9
  - Any other pattern, including 1111111, stores nibble F and sets the error accumulator.
- State machine:
  - SYNC:
    - Captures of k≠0 are ignored silently.
    - Capture of k=0: store slot 0, accumulator = illegal-pattern flag of this digit only, expected=1, go to COLLECT.
  - COLLECT:
    - Capture of k==expected: store slot k, OR in its illegal flag, expected+1.
    - Capture of k=0: restart the frame (slot 0, accumulator reset to this digit's flag, expected=1), no seq_err.
    - Any other k: seq_err pulse, discard the partial frame, go to SYNC.
- Publish:
  - Trigger: the edge that stores slot NUM_DIGITS-1.
  - On that edge: value_out takes all slots, with the new digit included; frame_err takes the final accumulator; frame_valid goes high for exactly the following cycle; state goes to SYNC.
  - With NUM_DIGITS=1, every digit-0 capture publishes directly from SYNC.
- Latency: the last digit's pair is applied before edge 1 and held → frame_valid is high after edge STABLE_CYCLES.
- value_out and frame_err hold between publishes. Partial frames never alter outputs.
- Reset mid-frame: all progress is lost; the first frame after release begins at the next digit-0 capture.

Test Plan:
1. NUM_DIGITS=4, STABLE_CYCLES=4. Scan digits 0..3 with patterns for 3,2,1,0 (0110000, 0100100, 1111001, 1000000), 6 cycles each, blank gaps → one frame_valid pulse, value_out=16'h0123, frame_err=0, seq_err never set.
2. Same scan, but digit 2 shows 1111111 → value_out=16'h0F23, frame_err=1. The next clean frame returns frame_err=0.
3. Digit 1 held only 3 cycles, then digits 2,3 → no frame_valid. A seq_err pulse on the digit 2 capture (expected 1). value_out keeps its previous value.
4. an_in=4'b1100 stable for 4 cycles in COLLECT → seq_err pulse. A subsequent full 0..3 scan publishes normally.
5. Digits 0,1, then 0 again, then 1,2,3 with values 9,8,7,6 → single publish value_out=16'h6789, no seq_err. A 20-cycle dwell on one digit produces exactly one capture.
6. Assert rst_n low mid-COLLECT (after digits 0,1), asynchronously between edges → all outputs 0 immediately. Resume the scan at digit 2 → no publish until a full 0..3 scan completes.
